spi_frame_receiver: RTL and testbench

SPI_FRAME_RECEIVER -- requirements
Module: spi_frame_receiver

---
 rtl/spi_frame_receiver.sv | 142 ++++++++++++++
 tb/tb_spi_frame_receiver.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_frame_receiver.sv
// Receives 32-bit LSB-first SPI frames framed by an spi_clk idle timeout and
// reports each as accepted, header error or length error.
module spi_frame_receiver #(
    parameter int          TIMEOUT_CYCLES = 16,
    parameter logic [7:0]  HEADER         = 8'hAA
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        spi_clk,
    input  logic        spi_mosi,
    output logic [23:0] position,
    output logic [31:0] frame_word,
    output logic        frame_valid,
    output logic        header_err,
    output logic        len_err,
    output logic        busy,
    output logic [7:0]  err_count
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        CHECK
    } state_t;

    state_t          state, state_nxt;
    logic [1:0]      sclk_sync, mosi_sync;
    logic            sclk_prev;
    logic            rise;
    logic [31:0]     shreg, shreg_nxt;
    logic [5:0]      bit_cnt, bit_cnt_nxt;
    logic [TW-1:0]   tcnt, tcnt_nxt;
    logic            frame_ok, hdr_bad, len_bad;

    // Both SPI inputs see the same two-flop delay so data stays aligned with its edge.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync <= '0;
            mosi_sync <= '0;
            sclk_prev <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[0], spi_clk};
            mosi_sync <= {mosi_sync[0], spi_mosi};
            sclk_prev <= sclk_sync[1];
        end
    end

    assign rise = sclk_sync[1] & ~sclk_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
            tcnt    <= '0;
        end else begin
            state   <= state_nxt;
            shreg   <= shreg_nxt;
            bit_cnt <= bit_cnt_nxt;
            tcnt    <= tcnt_nxt;
        end
    end

    // NOTE: every output of this block is defaulted first so no path infers a latch.
    always_comb begin
        state_nxt   = state;
        shreg_nxt   = shreg;
        bit_cnt_nxt = bit_cnt;
        tcnt_nxt    = tcnt;
        frame_ok    = 1'b0;
        hdr_bad     = 1'b0;
        len_bad     = 1'b0;

        case (state)
            IDLE: begin
                if (rise) begin
                    shreg_nxt   = {mosi_sync[1], shreg[31:1]};
                    bit_cnt_nxt = 6'd1;
                    tcnt_nxt    = '0;
                    state_nxt   = RECV;
                end
            end
            RECV: begin
                if (rise) begin
                    shreg_nxt = {mosi_sync[1], shreg[31:1]};
                    if (bit_cnt != 6'd63) begin
                        bit_cnt_nxt = bit_cnt + 6'd1;
                    end
                    tcnt_nxt = '0;
                end else begin
                    tcnt_nxt = tcnt + 1'b1;
                    // The count reaching the limit on this edge is what ends the frame.
                    if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
                        state_nxt = CHECK;
                    end
                end
            end
            CHECK: begin
                // Edges seen here are dropped; the frame is already closed.
                state_nxt = IDLE;
                if (bit_cnt == 6'd32) begin
                    if (shreg[31:24] == HEADER) begin
                        frame_ok = 1'b1;
                    end else begin
                        hdr_bad = 1'b1;
                    end
                end else begin
                    len_bad = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_valid <= 1'b0;
            header_err  <= 1'b0;
            len_err     <= 1'b0;
            position    <= '0;
            frame_word  <= '0;
            err_count   <= '0;
        end else begin
            frame_valid <= frame_ok;
            header_err  <= hdr_bad;
            len_err     <= len_bad;
            if (frame_ok) begin
                position   <= shreg[23:0];
                frame_word <= shreg;
            end
            if ((hdr_bad || len_bad) && (err_count != 8'hFF)) begin
                err_count <= err_count + 8'd1;
            end
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_spi_frame_receiver.sv
// Self-checking bench for spi_frame_receiver: directed frames plus random frames
// compared every cycle against a frame-level behavioural model.
module tb_spi_frame_receiver;

    localparam int         T   = 16;
    localparam logic [7:0] HDR = 8'hAA;
    localparam int         BIG = 1 << 30;
    localparam int         K_VALID = 0, K_HDR = 1, K_LEN = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        spi_clk = 1'b0;
    logic        spi_mosi = 1'b0;
    logic [23:0] position;
    logic [31:0] frame_word;
    logic        frame_valid, header_err, len_err, busy;
    logic [7:0]  err_count;

    spi_frame_receiver #(.TIMEOUT_CYCLES(T), .HEADER(HDR)) dut (
        .clk(clk), .rst_n(rst_n), .spi_clk(spi_clk), .spi_mosi(spi_mosi),
        .position(position), .frame_word(frame_word), .frame_valid(frame_valid),
        .header_err(header_err), .len_err(len_err), .busy(busy), .err_count(err_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int total = 0;
    int bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Model: outputs after the last result, plus the one result still pending.
    logic [23:0] m_pos = '0;
    logic [31:0] m_word = '0;
    int          m_err = 0;
    int          pend_cyc = -1;
    int          pend_kind = K_VALID;
    logic [31:0] pend_word = '0;
    int          busy_lo = BIG;
    int          busy_hi = BIG;
    int          last_rise = 0;
    bit          chk_en = 1'b0;
    int          fv_seen = 0, he_seen = 0, le_seen = 0, fv_cyc = 0;
    logic        e_fv, e_he, e_le;

    always @(negedge clk) begin
        if (chk_en) begin
            e_fv = 1'b0;
            e_he = 1'b0;
            e_le = 1'b0;
            if (cyc == pend_cyc) begin
                if (pend_kind == K_VALID) begin
                    e_fv   = 1'b1;
                    m_pos  = pend_word[23:0];
                    m_word = pend_word;
                end else begin
                    if (pend_kind == K_HDR) e_he = 1'b1;
                    else                    e_le = 1'b1;
                    if (m_err < 255) m_err++;
                end
            end
            check("frame_valid", frame_valid, e_fv);
            check("header_err", header_err, e_he);
            check("len_err", len_err, e_le);
            check("position", position, m_pos);
            check("frame_word", frame_word, m_word);
            check("err_count", err_count, m_err);
            check("busy", busy, (cyc >= busy_lo) && (cyc <= busy_hi));
            if (frame_valid) begin
                fv_seen++;
                fv_cyc = cyc;
            end
            if (header_err) he_seen++;
            if (len_err)    le_seen++;
        end
    end

    task automatic do_reset();
        @(negedge clk);
        chk_en   = 1'b0;
        rst_n    = 1'b0;
        spi_clk  = 1'b0;
        spi_mosi = 1'b0;
        repeat (3) @(negedge clk);
        check("rst position", position, 0);
        check("rst frame_word", frame_word, 0);
        check("rst pulses", {frame_valid, header_err, len_err}, 0);
        check("rst busy", busy, 0);
        check("rst err_count", err_count, 0);
        rst_n     = 1'b1;
        m_pos     = '0;
        m_word    = '0;
        m_err     = 0;
        pend_cyc  = -1;
        busy_lo   = BIG;
        busy_hi   = BIG;
        chk_en    = 1'b1;
    endtask

    // ph = 0 picks a random 1..3 clk length for every spi_clk phase.
    task automatic send_bits(input logic [63:0] bits, input int n, input int ph);
        int lo, hi;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            spi_clk  = 1'b0;
            spi_mosi = bits[i];
            lo = (ph != 0) ? ph : int'($urandom_range(1, 3));
            hi = (ph != 0) ? ph : int'($urandom_range(1, 3));
            repeat (lo - 1) @(negedge clk);
            @(negedge clk);
            spi_clk = 1'b1;
            if (i == 0) begin
                busy_lo = cyc + 3;
                busy_hi = BIG;
            end
            last_rise = cyc;
            repeat (hi - 1) @(negedge clk);
        end
    endtask

    // Rise driven at cyc c is detected at c+2 after the synchronizer; result at +T+2.
    task automatic finish_frame(input logic [63:0] bits, input int n);
        @(negedge clk);
        spi_clk = 1'b0;
        pend_word = bits[31:0];
        if (n != 32)                pend_kind = K_LEN;
        else if (bits[31:24] != HDR) pend_kind = K_HDR;
        else                        pend_kind = K_VALID;
        busy_hi  = last_rise + T + 3;
        pend_cyc = last_rise + T + 4;
        while (cyc <= pend_cyc + 2) @(negedge clk);
    endtask

    task automatic send_frame(input logic [63:0] bits, input int n, input int ph);
        send_bits(bits, n, ph);
        finish_frame(bits, n);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int fv0, le0, he0;
        logic [63:0] w;
        int n;

        do_reset();

        // Good frame with the default header.
        fv0 = fv_seen;
        send_frame(64'hAA123456, 32, 2);
        check("t1 pulses", fv_seen - fv0, 1);
        check("t1 position", position, 24'h123456);
        check("t1 frame_word", frame_word, 32'hAA123456);
        check("t1 err_count", err_count, 0);

        // Wrong header leaves the accepted data alone.
        he0 = he_seen;
        send_frame(64'hAB123456, 32, 2);
        check("t2 header_err", he_seen - he0, 1);
        check("t2 position", position, 24'h123456);
        check("t2 err_count", err_count, 1);

        // Short and long frames.
        do_reset();
        fv0 = fv_seen;
        le0 = le_seen;
        send_frame(64'h0_AA123456, 31, 2);
        send_frame(64'h1_AA123456, 33, 2);
        check("t3 len_err", le_seen - le0, 2);
        check("t3 no valid", fv_seen - fv0, 0);
        check("t3 err_count", err_count, 2);

        // Reset in the middle of a frame.
        send_bits(64'hAA123456, 10, 2);
        do_reset();
        fv0 = fv_seen;
        le0 = le_seen;
        send_frame(64'hAA00FFEE, 32, 2);
        check("t4 valid", fv_seen - fv0, 1);
        check("t4 no len_err", le_seen - le0, 0);
        check("t4 position", position, 24'h00FFEE);

        // Latency: 2 synchronizer cycles plus T+2 after detection.
        fv0 = fv_seen;
        send_frame(64'hAA654321, 32, 1);
        check("t5 valid", fv_seen - fv0, 1);
        check("t5 latency", fv_cyc - last_rise, 20);

        // Error counter saturation.
        for (int k = 0; k < 300; k++) send_frame(64'(k & 1), 1, 1);
        check("t6 err_count sat", err_count, 8'hFF);
        fv0 = fv_seen;
        send_frame(64'hAA0BCDEF, 32, 2);
        check("t6 valid after sat", fv_seen - fv0, 1);
        check("t6 position", position, 24'h0BCDEF);

        // Random frames with random phase lengths.
        for (int k = 0; k < 40; k++) begin
            w = {32'($urandom), 32'($urandom)};
            if ($urandom_range(0, 1) == 1) w[31:24] = HDR;
            n = ($urandom_range(0, 9) < 6) ? 32 : int'($urandom_range(1, 40));
            send_frame(w, n, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
